// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - producer/consumer handshake bundle for the control-word pipe
interface ctrl_pipe_if #(
  parameter int CW_W = 64
);
  logic            in_valid;
  logic [CW_W-1:0] in_cw;
  logic            in_ready;
  logic            out_valid;
  logic [CW_W-1:0] out_cw;
  logic            out_ready;

  modport master (
    output in_valid, in_cw, out_ready,
    input  in_ready, out_valid, out_cw
  );

  modport slave (
    input  in_valid, in_cw, out_ready,
    output in_ready, out_valid, out_cw
  );
endinterface

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - elastic control-word pipeline with per-stage stall/flush and bubble collapse
module ctrl_pipe #(
  parameter int STAGES = 4,
  parameter int CW_W   = 64,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  ctrl_pipe_if.slave        bus,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  output logic [OCC_W-1:0]  occupancy
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ve;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] nxt_v;
  logic [CW_W-1:0]   p     [STAGES];
  logic [CW_W-1:0]   nxt_p [STAGES];

  // Flush masks a stage before any hold decision, so a squashed stage never blocks upstream.
  assign ve = v & ~flush;

  always_comb begin : hold_chain
    logic down;
    hold = '0;
    down = ve[STAGES-1] & (stall[STAGES-1] | ~bus.out_ready);
    hold[STAGES-1] = down;
    for (int k = STAGES - 2; k >= 0; k--) begin
      down    = ve[k] & (stall[k] | down);
      hold[k] = down;
    end
  end

  always_comb begin : next_state
    logic fwd;
    fwd   = 1'b0;
    nxt_v = '0;
    for (int k = 0; k < STAGES; k++) begin
      nxt_p[k] = '0;
    end

    nxt_v[0] = hold[0] ? ve[0] : bus.in_valid;
    nxt_p[0] = hold[0] ? p[0] : (bus.in_valid ? bus.in_cw : '0);

    // A stage that does not receive a word takes payload 0, so bubbles are always clean.
    for (int k = 1; k < STAGES; k++) begin
      fwd      = ve[k-1] & ~hold[k-1];
      nxt_v[k] = hold[k] ? ve[k] : fwd;
      nxt_p[k] = hold[k] ? p[k] : (fwd ? p[k-1] : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        p[k] <= '0;
      end
    end else begin
      v <= nxt_v;
      for (int k = 0; k < STAGES; k++) begin
        p[k] <= nxt_p[k];
      end
    end
  end

  always_comb begin : occ_count
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

  assign bus.in_ready  = ~hold[0];
  assign bus.out_valid = ve[STAGES-1];
  assign bus.out_cw    = p[STAGES-1];

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed and randomized checks of ctrl_pipe against a slot-occupancy model
module tb_ctrl_pipe;
  localparam int STAGES = 4;
  localparam int CW_W   = 64;
  localparam int OCC_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic [OCC_W-1:0]  occupancy;

  ctrl_pipe_if #(.CW_W(CW_W)) bus ();

  ctrl_pipe #(.STAGES(STAGES), .CW_W(CW_W), .OCC_W(OCC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall     (stall),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: each slot either holds a word or is empty; empty slots read as payload 0.
  bit          m_v [STAGES];
  logic [63:0] m_p [STAGES];

  logic        obs_ready;
  logic        obs_valid;
  logic [63:0] obs_cw;
  logic [63:0] obs_occ;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: drive inputs, predict with the model, compare, then commit the model at the edge.
  task automatic step(input bit r, input bit iv, input logic [63:0] cw,
                      input logic [3:0] st, input logic [3:0] fl, input bit ordy);
    bit          live [STAGES];
    bit          slot [STAGES];
    logic [63:0] sp   [STAGES];
    bit          exp_ready;
    int          cnt;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_cw     = cw;
    stall         = st;
    flush         = fl;
    bus.out_ready = ordy;

    cnt = 0;
    for (int k = 0; k < STAGES; k++) begin
      live[k] = m_v[k] && !fl[k];
      slot[k] = live[k];
      sp[k]   = live[k] ? m_p[k] : 64'd0;
      cnt    += int'(m_v[k]);
    end
    if (slot[STAGES-1] && !st[STAGES-1] && ordy) begin
      slot[STAGES-1] = 1'b0;
      sp[STAGES-1]   = 64'd0;
    end
    for (int k = STAGES - 2; k >= 0; k--) begin
      if (slot[k] && !st[k] && !slot[k+1]) begin
        slot[k+1] = 1'b1;
        sp[k+1]   = sp[k];
        slot[k]   = 1'b0;
        sp[k]     = 64'd0;
      end
    end
    exp_ready = !slot[0];
    if (exp_ready && iv) begin
      slot[0] = 1'b1;
      sp[0]   = cw;
    end

    #1;
    obs_ready = bus.in_ready;
    obs_valid = bus.out_valid;
    obs_cw    = bus.out_cw;
    obs_occ   = 64'(occupancy);
    if (!r) begin
      chk("model_in_ready",  64'(obs_ready), 64'(exp_ready));
      chk("model_out_valid", 64'(obs_valid), 64'(live[STAGES-1]));
      chk("model_out_cw",    obs_cw,         m_p[STAGES-1]);
      chk("model_occupancy", obs_occ,        64'(cnt));
    end

    @(posedge clk);
    for (int k = 0; k < STAGES; k++) begin
      m_v[k] = r ? 1'b0 : slot[k];
      m_p[k] = r ? 64'd0 : sp[k];
    end
  endtask

  initial begin
    for (int k = 0; k < STAGES; k++) begin
      m_v[k] = 1'b0;
      m_p[k] = 64'd0;
    end

    step(1'b1, 1'b0, 64'd0, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 1'b0, 64'd0, 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 64'd0, 4'b0000, 4'b0000, 1'b0);
    chk("reset_occupancy", obs_occ, 64'd0);
    chk("reset_in_ready", 64'(obs_ready), 64'd1);
    chk("reset_out_valid", 64'(obs_valid), 64'd0);
    chk("reset_out_cw", obs_cw, 64'd0);

    // Free-running stream of 1,2,3,...
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 64'(i), 4'b0000, 4'b0000, 1'b1);
      if (i == 4) chk("stream_not_yet_valid", 64'(obs_valid), 64'd0);
      if (i == 5) begin
        chk("stream_first_valid", 64'(obs_valid), 64'd1);
        chk("stream_first_cw", obs_cw, 64'd1);
      end
      if (i == 9) begin
        chk("stream_cw_seq", obs_cw, 64'd5);
        chk("stream_occ_full", obs_occ, 64'd4);
      end
    end

    // Consumer backpressure on a full pipe, then release.
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b1, 64'd13, 4'b0000, 4'b0000, 1'b0);
      chk("bp_in_ready_low", 64'(obs_ready), 64'd0);
      chk("bp_out_cw_frozen", obs_cw, 64'd9);
      chk("bp_occ_full", obs_occ, 64'd4);
    end
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 1'b1, 64'(13 + j), 4'b0000, 4'b0000, 1'b1);
      chk("bp_resume_seq", obs_cw, 64'(9 + j));
    end

    // Lone word in the last stage, consumer blocked: bubbles collapse behind it.
    step(1'b1, 1'b0, 64'd0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 64'd9, 4'b0000, 4'b0000, 1'b0);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 64'd0, 4'b0000, 4'b0000, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b1, 64'(20 + j), 4'b0000, 4'b0000, 1'b0);
      chk("collapse_in_ready", 64'(obs_ready), 64'(j < 3));
      chk("collapse_out_cw", obs_cw, 64'd9);
    end

    // One-cycle stall of stage 1 in a full stream inserts exactly one bubble.
    step(1'b1, 1'b0, 64'd0, 4'b0000, 4'b0000, 1'b1);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 64'(100 + i), 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 64'd107, 4'b0010, 4'b0000, 1'b1);
    chk("stall_in_ready_low", 64'(obs_ready), 64'd0);
    chk("stall_out_cw", obs_cw, 64'd103);
    step(1'b0, 1'b1, 64'd107, 4'b0000, 4'b0000, 1'b1);
    chk("stall_next_cw", obs_cw, 64'd104);
    step(1'b0, 1'b1, 64'd108, 4'b0000, 4'b0000, 1'b1);
    chk("stall_gap_valid", 64'(obs_valid), 64'd0);
    chk("stall_gap_cw", obs_cw, 64'd0);
    step(1'b0, 1'b1, 64'd109, 4'b0000, 4'b0000, 1'b1);
    chk("stall_after_gap_cw", obs_cw, 64'd105);
    for (int i = 110; i <= 113; i++) step(1'b0, 1'b1, 64'(i), 4'b0000, 4'b0000, 1'b1);

    // Squash the output word, then squash a stalled stage 2.
    step(1'b0, 1'b1, 64'd114, 4'b0000, 4'b1000, 1'b1);
    chk("flush_last_no_valid", 64'(obs_valid), 64'd0);
    step(1'b0, 1'b1, 64'd115, 4'b0100, 4'b0100, 1'b1);
    chk("flush_wins_over_stall", 64'(obs_ready), 64'd1);
    for (int i = 116; i <= 120; i++) step(1'b0, 1'b1, 64'(i), 4'b0000, 4'b0000, 1'b1);

    // Mid-stream reset on a full, blocked pipe.
    step(1'b0, 1'b1, 64'd121, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 64'd122, 4'b1111, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 64'd0, 4'b0000, 4'b0000, 1'b0);
    chk("midrst_occupancy", obs_occ, 64'd0);
    chk("midrst_out_valid", 64'(obs_valid), 64'd0);
    chk("midrst_in_ready", 64'(obs_ready), 64'd1);
    chk("midrst_out_cw", obs_cw, 64'd0);

    // Random traffic with sparse stalls, flushes and resets.
    for (int n = 0; n < 800; n++) begin
      logic [3:0] st;
      logic [3:0] fl;
      st = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      fl = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      step(($urandom_range(0, 99) == 0), 1'($urandom), {$urandom, $urandom},
           st, fl, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
